// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// One DATA_BITS word per valid/ready handshake is framed as start bit,
// LSB-first data, optional even/odd parity and one or two stop bits.
// Bit timing comes from a clock-enable counter in the clk domain.
module uart_tx_param #(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,   // 0 = none, 1 = even, 2 = odd
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 donetx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    // Parameter sanity: a bad configuration must never build silently.
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $fatal(1, "uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;     // data bit index, reused as stop-bit index
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   tx_q, tx_d;
    logic                   donetx_q, donetx_d;

    logic                   bit_end;
    logic                   parity_bit;

    assign bit_end    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign parity_bit = (PARITY == 2) ? ~(^data_q) : (^data_q);

    // State, counters, latched word and the registered line output.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            tx_q     <= 1'b1;
            donetx_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
            donetx_q <= donetx_d;
        end
    end

    // Next-state logic; tx_d is the line level the next state must show.
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        tx_d     = tx_q;
        donetx_d = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    data_d  = tx_data;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = data_q[idx_q + IDX_W'(1)];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_d  = ST_IDLE;
                        idx_d    = '0;
                        donetx_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign tx_ready = (state_q == ST_IDLE);
    assign donetx   = donetx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for uart_tx_param.
// Four instances (8N1, 8E1, 8O1, 7N2) at 10 clks/bit share clk and rst.
// Stimulus pushes hand-computed expected frames; a monitor records the line
// of the selected instance and compares each frame when donetx pulses.
module tb_uart_tx_param;

    localparam int CPB = 10;
    localparam int NB  [4] = '{8, 8, 8, 7};
    localparam int PAR [4] = '{0, 1, 2, 0};
    localparam int STB [4] = '{1, 1, 1, 2};

    typedef struct {
        logic [8:0] data;
        logic       par;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] dat = '0;
    logic       vld [4];
    logic       tx_w [4];
    logic       busy_w [4];
    logic       done_w [4];
    logic       ready_w [4];

    int   sel = 0;
    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    int   last_high_run = 0;
    logic s [0:511];

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[7:0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .donetx(done_w[0]));

    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[7:0]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .donetx(done_w[1]));

    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[7:0]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .donetx(done_w[2]));

    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                    .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(dat[6:0]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .donetx(done_w[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare one recorded frame of length len against the scoreboard head.
    task automatic score_frame(input int len, input int busy_cnt, input logic busy_now);
        exp_t       e;
        logic [8:0] d;
        int         nb, pb, nslots, bad, stop_bad;
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        e  = exp_q.pop_front();
        nb = NB[sel];
        pb = (PAR[sel] != 0) ? 1 : 0;
        nslots = 1 + nb + pb + STB[sel];
        check("frame_len", len, e.len);
        check("busy_cycles", busy_cnt, e.len);
        check("busy_at_done", busy_now, 0);
        check("start_bit", s[0], 0);
        bad = 0;
        for (int b = 0; b < nslots; b++)
            for (int j = 0; j < CPB; j++)
                if (s[b*CPB + j] !== s[b*CPB]) bad++;
        check("bit_stable", bad, 0);
        d = '0;
        for (int i = 0; i < nb; i++) d[i] = s[(1 + i)*CPB];
        check("data", d, e.data);
        if (pb != 0) check("parity", s[(1 + nb)*CPB], e.par);
        stop_bad = 0;
        for (int k = 0; k < STB[sel]; k++)
            if (s[(1 + nb + pb + k)*CPB] !== 1'b1) stop_bad++;
        check("stop_bits", stop_bad, 0);
    endtask

    // Monitor: samples the selected instance on the falling edge.
    initial begin : monitor
        int   idx = 0;
        int   busy_cnt = 0;
        int   high_run = 0;
        bit   in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                high_run = 0;
            end else begin
                if (!in_frame) begin
                    if (done_w[sel]) check("stray_donetx", done_w[sel], 0);
                    if (tx_w[sel] === 1'b0) begin
                        in_frame      = 1'b1;
                        idx           = 0;
                        busy_cnt      = 0;
                        last_high_run = high_run;
                    end
                end
                if (in_frame) begin
                    if (done_w[sel]) begin
                        done_cnt++;
                        check("line_at_done", tx_w[sel], 1);
                        score_frame(idx, busy_cnt, busy_w[sel]);
                        in_frame = 1'b0;
                    end else begin
                        s[idx] = tx_w[sel];
                        if (busy_w[sel]) busy_cnt++;
                        idx++;
                        if (idx > 300) begin
                            check("frame_timeout", idx, 0);
                            in_frame = 1'b0;
                        end
                    end
                end
                high_run = (tx_w[sel] === 1'b1) ? high_run + 1 : 0;
            end
        end
    end

    // Issue one word to instance k; optionally push its expected frame.
    task automatic send(input int k, input logic [8:0] d, input bit push,
                        input logic [8:0] exp_d, input logic exp_p, input int exp_len);
        int guard;
        exp_t e;
        if (push) begin
            e.data = exp_d;
            e.par  = exp_p;
            e.len  = exp_len;
            exp_q.push_back(e);
        end
        @(negedge clk);
        guard = 0;
        while (!ready_w[k] && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_send", ready_w[k], 1);
        dat    = d;
        vld[k] = 1'b1;
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
        dat    = 9'h1A6;   // junk after accept must not reach the line
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || busy_w[sel]) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin : stimulus
        int done_before;
        int busy_seen;
        int guard;
        for (int k = 0; k < 4; k++) vld[k] = 1'b0;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_tx", tx_w[k], 1);
            check("rst_busy", busy_w[k], 0);
            check("rst_ready", ready_w[k], 1);
            check("rst_donetx", done_w[k], 0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 8N1, 0xA5.
        sel = 0;
        send(0, 9'h0A5, 1'b1, 9'h0A5, 1'b0, 100);
        wait_idle();

        // Even parity then odd parity: 0x07 and 0x03.
        sel = 1;
        send(1, 9'h007, 1'b1, 9'h007, 1'b1, 110);
        wait_idle();
        send(1, 9'h003, 1'b1, 9'h003, 1'b0, 110);
        wait_idle();
        sel = 2;
        send(2, 9'h007, 1'b1, 9'h007, 1'b0, 110);
        wait_idle();
        send(2, 9'h003, 1'b1, 9'h003, 1'b1, 110);
        wait_idle();

        // 7N2 with junk in bus bit 7.
        sel = 3;
        send(3, 9'h0FF, 1'b1, 9'h07F, 1'b0, 100);
        wait_idle();

        // Back-to-back 0x55 then 0xAA with tx_valid held high.
        sel = 0;
        repeat (2) @(negedge clk);
        exp_q.push_back('{9'h055, 1'b0, 100});
        dat    = 9'h055;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        dat = 9'h0AA;
        exp_q.push_back('{9'h0AA, 1'b0, 100});
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done_w[0] && guard < 300);
        check("b2b_ready_on_done", ready_w[0], 1);
        @(posedge clk);
        #1;
        check("b2b_accepted", busy_w[0], 1);
        vld[0] = 1'b0;
        wait_idle();
        check("b2b_high_gap", last_high_run, 11);

        // Asynchronous reset 35 clks into a 0xF0 frame.
        repeat (3) @(negedge clk);
        done_before = done_cnt;
        send(0, 9'h0F0, 1'b0, 9'h000, 1'b0, 0);
        repeat (34) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_tx", tx_w[0], 1);
        check("abort_busy", busy_w[0], 0);
        check("abort_ready", ready_w[0], 1);
        check("abort_donetx", done_w[0], 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        check("abort_no_done", done_cnt, done_before);
        send(0, 9'h03C, 1'b1, 9'h03C, 1'b0, 100);
        wait_idle();

        // tx_valid pulse with 0xFF mid-frame of 0x00 must be ignored.
        done_before = done_cnt;
        send(0, 9'h000, 1'b1, 9'h000, 1'b0, 100);
        repeat (39) @(posedge clk);
        @(negedge clk);
        dat    = 9'h0FF;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        wait_idle();
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_w[0]) busy_seen++;
        end
        check("ignored_no_frame", busy_seen, 0);
        check("one_done_per_word", done_cnt, done_before + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Serialises one DATA_BITS-wide word per valid/ready handshake into a framed asynchronous stream: start bit, LSB-first data, optional parity, 1 or 2 stop bits. Bit timing comes from a clock-enable divider in the single clk domain, with no derived clocks. It sits between a producer (FIFO or CPU register) and the tx pin, and is the drop-in successor to the fixed 8N1 transmitter.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer floor), must be >= 2
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tx_valid  input  1  producer has a word on tx_data
tx_data  input  DATA_BITS  word to send; sampled only on accept
tx_ready  output  1  block can accept a word (high only in IDLE)
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in progress (any state except IDLE)
donetx  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (async assert): state = IDLE, tx = 1, busy = 0, donetx = 0, baud counter = 0, bit index = 0. tx_ready is 1 whenever state = IDLE, including during reset.
- Reset mid-frame: frame aborts immediately, tx returns to 1, no donetx pulse. The first frame after reset release is normal.
- Accept: on a rising edge with state = IDLE and tx_valid = 1:
  - tx_data is latched into a shift register.
  - State moves to START and the baud counter clears.
  - tx = 0 from the cycle after accept. Latency from accept edge to start bit is 1 clk.
- tx_valid while not IDLE is ignored: no queueing, no effect on the frame in flight. tx_data changes after accept have no effect.
- Baud counter runs 0..CLKS_PER_BIT-1. Every bit holds tx constant for exactly CLKS_PER_BIT cycles. The counter wraps to 0 at each bit boundary.
- States: IDLE, START, DATA, PARITY, STOP.
  - START: tx = 0 for one bit time, then go to DATA.
  - DATA: tx = data[i] for i = 0..DATA_BITS-1, LSB first. Bit index increments at each bit boundary. After the last data bit, go to PARITY if PARITY != 0, else STOP.
  - PARITY: tx = XOR of all latched data bits for even; the inverse of that XOR for odd. One bit time, then go to STOP.
  - STOP: tx = 1 for STOP_BITS bit times. On the final count, state = IDLE and donetx = 1 for exactly that one cycle.
- Frame length from the first start-bit cycle to the end of stop: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back: if tx_valid is high in the first IDLE cycle (the cycle where donetx = 1), the next word is accepted at that cycle's edge.
  - The minimum inter-frame idle is therefore 1 clk.
  - The line shows CLKS_PER_BIT*STOP_BITS + 1 high cycles between frames.
- Unused upper bits: DATA_BITS < 9 uses only tx_data[DATA_BITS-1:0].
- Illegal parameters (CLKS_PER_BIT < 2, DATA_BITS outside 5..9, PARITY > 2, STOP_BITS not 1 or 2) are fatal at elaboration.

Test Plan:
1. 8N1, CLK_FREQ = 1000000, BAUD_RATE = 100000 (10 clks/bit). Send 0xA5.
   -> tx is low for 10 clks, then bits 1,0,1,0,0,1,0,1 at 10 clks each, then high for 10.
   -> donetx pulses 100 clks after the start bit begins; busy is high for exactly those 100 clks.
2. PARITY = 1 then PARITY = 2, DATA_BITS = 8. Send 0x07.
   -> Parity bit = 1 for even, 0 for odd; frame is 110 clks.
   -> Repeat with 0x03: parity bit = 0 for even, 1 for odd.
3. DATA_BITS = 7, STOP_BITS = 2, PARITY = 0. Send 0x7F (upper tx_data bit set to 1 as junk).
   -> 7 ones follow the start bit, then 20 clks of high; frame is 100 clks; bit 7 is never driven.
4. Back-to-back: hold tx_valid high with 0x55 then 0xAA.
   -> The second accept occurs on the donetx cycle; the line is high for 11 clks between frames.
   -> Second frame bits are 0,1,0,1,0,1,0,1.
5. Assert rst asynchronously 35 clks into a 0xF0 frame.
   -> tx = 1 and busy = 0 in the same cycle, tx_ready = 1, no donetx.
   -> After release, 0x3C transmits correctly.
6. Pulse tx_valid with 0xFF at clk 40 of a 0x00 frame.
   -> Ignored: the line shows eight 0 data bits, and exactly one donetx per accepted word.
